// File: rtl/mio_pkg.sv
// Shared definitions for the MIO two-master memory arbiter: FSM encoding,
// one-hot grant codes and default bus widths.
package mio_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned GNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // One-hot owner encoding {m1, m0}
    localparam logic [GNT_W-1:0] GNT_NONE = 2'b00;
    localparam logic [GNT_W-1:0] GNT_M0   = 2'b01;
    localparam logic [GNT_W-1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/mio_rr_pick.sv
// Combinational two-way picker: returns the one-hot winner among the pending
// requests, alternating on contention when round-robin is enabled.
module mio_rr_pick
    import mio_pkg::*;
#(
    parameter int unsigned RR_ENABLE = 1
) (
    input  logic [GNT_W-1:0] req,
    input  logic [GNT_W-1:0] last_grant,
    output logic [GNT_W-1:0] win_c
);

    always_comb begin
        win_c = GNT_NONE;
        case (req)
            2'b01:   win_c = GNT_M0;
            2'b10:   win_c = GNT_M1;
            // Contention: m1 only wins when round-robin is on and m0 had the last turn
            2'b11:   win_c = ((RR_ENABLE != 0) && (last_grant == GNT_M0)) ? GNT_M1 : GNT_M0;
            default: win_c = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master, one-slave memory arbiter: picks an owner in IDLE, drives a fixed
// wait-state access to the shared memory, then returns a one-cycle ready pulse.
module mio_bus_arbiter
    import mio_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RR_ENABLE   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [GNT_W-1:0]  grant
);

    localparam int unsigned CNT_W = 4;

    state_e            state_q, state_d;
    logic [GNT_W-1:0]  grant_q, grant_d;
    logic [GNT_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              m0_ready_q, m0_ready_d;
    logic              m1_ready_q, m1_ready_d;
    logic [GNT_W-1:0]  win_c;

    mio_rr_pick #(
        .RR_ENABLE (RR_ENABLE)
    ) u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .win_c      (win_c)
    );

    // mem_addr/mem_wdata/mem_we double as the latched request of the current owner
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_c != GNT_NONE) begin
                    grant_d      = win_c;
                    last_grant_d = win_c;
                    cnt_d        = CNT_W'(WAIT_CYCLES);
                    mem_en_d     = 1'b1;
                    mem_we_d     = win_c[1] ? m1_we    : m0_we;
                    mem_addr_d   = win_c[1] ? m1_addr  : m0_addr;
                    mem_wdata_d  = win_c[1] ? m1_wdata : m0_wdata;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    mem_en_d = 1'b1;
                    mem_we_d = mem_we_q;
                end else begin
                    if (!mem_we_q) begin
                        if (grant_q[1]) m1_rdata_d = mem_rdata;
                        else            m0_rdata_d = mem_rdata;
                    end
                    m0_ready_d = grant_q[0];
                    m1_ready_d = grant_q[1];
                    state_d    = RESP;
                end
            end
            RESP: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
            default: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_NONE;
            last_grant_q <= GNT_M1;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
        end
    end

    assign grant     = grant_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_ready  = m0_ready_q;
    assign m1_ready  = m1_ready_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Scoreboard bench for mio_bus_arbiter: main instance (1 wait state, round-robin)
// plus two side instances for the zero/fifteen wait-state and fixed-priority builds.
`timescale 1ns/1ps
module tb_mio_bus_arbiter;
    import mio_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- main DUT (WAIT_CYCLES=1, RR_ENABLE=1) ----------------
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr, mem_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic          m0_ready, m1_ready, mem_en, mem_we;
    logic [1:0]    grant;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    assign mem_rdata = mem_en ? mem_fn(mem_addr) : 32'h0;

    mio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1), .RR_ENABLE(1)) dut (
        .clk(clk), .reset(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    // ---------------- side DUTs ----------------
    logic          a_rst, a_req0, a_req1, a_zero;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_mem_rdata;
    logic [DW-1:0] w0_m0_rdata, w0_m1_rdata, w0_mem_wdata, w15_m0_rdata, w15_m1_rdata, w15_mem_wdata;
    logic [AW-1:0] w0_mem_addr, w15_mem_addr;
    logic          w0_m0_ready, w0_m1_ready, w0_mem_en, w0_mem_we;
    logic          w15_m0_ready, w15_m1_ready, w15_mem_en, w15_mem_we;
    logic [1:0]    w0_grant, w15_grant;
    logic          a_done = 1'b0;

    assign a_zero      = 1'b0;
    assign a_addr      = 32'h0000_0040;
    assign a_wdata     = 32'h0;
    assign a_mem_rdata = 32'h0BAD_F00D;

    mio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .RR_ENABLE(0)) u_w0 (
        .clk(clk), .reset(a_rst),
        .m0_req(a_req0), .m0_we(a_zero), .m0_addr(a_addr), .m0_wdata(a_wdata),
        .m0_rdata(w0_m0_rdata), .m0_ready(w0_m0_ready),
        .m1_req(a_req1), .m1_we(a_zero), .m1_addr(a_addr), .m1_wdata(a_wdata),
        .m1_rdata(w0_m1_rdata), .m1_ready(w0_m1_ready),
        .mem_en(w0_mem_en), .mem_we(w0_mem_we), .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata),
        .mem_rdata(a_mem_rdata), .grant(w0_grant)
    );

    mio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(15), .RR_ENABLE(1)) u_w15 (
        .clk(clk), .reset(a_rst),
        .m0_req(a_req0), .m0_we(a_zero), .m0_addr(a_addr), .m0_wdata(a_wdata),
        .m0_rdata(w15_m0_rdata), .m0_ready(w15_m0_ready),
        .m1_req(a_zero), .m1_we(a_zero), .m1_addr(a_addr), .m1_wdata(a_wdata),
        .m1_rdata(w15_m1_rdata), .m1_ready(w15_m1_ready),
        .mem_en(w15_mem_en), .mem_we(w15_mem_we), .mem_addr(w15_mem_addr), .mem_wdata(w15_mem_wdata),
        .mem_rdata(a_mem_rdata), .grant(w15_grant)
    );

    // ---------------- checking helpers ----------------
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endfunction

    typedef struct {
        bit            m;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int unsigned   rdy;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- scoreboard monitor ----------------
    int unsigned   en_cnt = 0;
    logic [DW-1:0] shadow [2];

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            en_cnt    = 0;
            shadow[0] = '0;
            shadow[1] = '0;
        end else begin
            if (m0_ready && m1_ready) fail_evt("both_ready");
            if (mem_en) begin
                if (exp_q.size() == 0) begin
                    fail_evt("spurious_mem_en");
                end else begin
                    e = exp_q[0];
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    en_cnt++;
                end
            end
            if (m0_ready || m1_ready) begin
                if (exp_q.size() == 0) begin
                    fail_evt("spurious_ready");
                end else begin
                    e = exp_q.pop_front();
                    chk("ready_owner", 32'({m1_ready, m0_ready}), e.m ? 32'(GNT_M1) : 32'(GNT_M0));
                    chk("resp_grant", 32'(grant), e.m ? 32'(GNT_M1) : 32'(GNT_M0));
                    chk("ready_cycle", cyc, e.rdy);
                    chk("mem_en_cycles", en_cnt, 32'd2);
                    chk("owner_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
                    chk("other_rdata", e.m ? m0_rdata : m1_rdata, e.m ? shadow[0] : shadow[1]);
                    shadow[e.m] = e.rdata;
                    en_cnt      = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_exp(input bit m, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                            input int unsigned rdy);
        exp_t e;
        e.m = m; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input bit m);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = m ? m1_ready : m0_ready;
        end
        if (!seen) fail_evt("ready_timeout");
    endtask

    // One access from IDLE; expected ready two cycles after the first mem_en cycle
    task automatic single(input bit m, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        push_exp(m, we, addr, wdata, rdata, cyc + 3);
        if (m) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else   begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        wait_ready(m);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int unsigned c;
        int          nrdy;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        do_reset();

        // reset values
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_grant", 32'(grant), 32'(GNT_NONE));
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);

        // m0 read 0x100
        single(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
        // m1 write 0x55AA to 0x2000, m1_rdata stays at reset value
        single(1'b1, 1'b1, 32'h0000_2000, 32'h0000_55AA, 32'h0);

        // m0 changes its inputs and drops req once granted
        c = cyc;
        push_exp(1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hFCFF_0300, c + 3);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0300;
        tick();
        m0_req = 1'b0; m0_we = 1'b1; m0_addr = 32'h0000_0444; m0_wdata = 32'h1234_5678;
        wait_ready(1'b0);
        tick();
        chk("post_resp_grant", 32'(grant), 32'(GNT_NONE));
        chk("post_resp_mem_en", 32'(mem_en), 32'd0);
        m0_we = 1'b0;

        // contention right after reset: m0, m1, m0, m1
        do_reset();
        c = cyc;
        push_exp(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hFFEF_0010, c + 3);
        push_exp(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'hFFDF_0020, c + 7);
        push_exp(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hFFEF_0010, c + 11);
        push_exp(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'hFFDF_0020, c + 15);
        m0_req = 1'b1; m0_addr = 32'h0000_0010;
        m1_req = 1'b1; m1_addr = 32'h0000_0020; m1_we = 1'b0;
        nrdy = 0;
        for (int i = 0; i < 60 && nrdy < 4; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) nrdy++;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("contention_ready_count", 32'(nrdy), 32'd4);
        tick();

        // reset during the second ACCESS cycle aborts the access
        push_exp(1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hFCFF_0300, cyc + 3);
        m0_req = 1'b1; m0_addr = 32'h0000_0300;
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        m0_req = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_m0_ready", 32'(m0_ready), 32'd0);
        chk("abort_grant", 32'(grant), 32'(GNT_NONE));
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_m0_rdata", m0_rdata, 32'd0);
        tick();
        rst = 1'b0;
        single(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);

        for (int i = 0; i < 200 && !a_done; i++) @(posedge clk);
        chk("side_done", 32'(a_done), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- side-instance stimulus and checks ----------------
    initial begin
        int unsigned c0;
        int unsigned n0;
        int unsigned n15;
        a_req0 = 1'b0;
        a_req1 = 1'b0;
        a_rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1 a_rst = 1'b0;
        c0 = cyc;
        a_req0 = 1'b1;
        a_req1 = 1'b1;
        n0  = 0;
        n15 = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (w0_m0_ready) begin
                chk("w0_ready_cycle", cyc - c0, 2 + 3 * n0);
                chk("w0_m0_rdata", w0_m0_rdata, 32'h0BAD_F00D);
                chk("w0_grant", 32'(w0_grant), 32'(GNT_M0));
                n0++;
            end
            if (w0_m1_ready) fail_evt("w0_m1_ready");
            if (w15_m0_ready) begin
                chk("w15_ready_cycle", cyc - c0, 17 + 18 * n15);
                n15++;
            end
        end
        chk("w0_ready_count", n0, 32'd26);
        chk("w15_ready_count", n15, 32'd4);
        a_req0 = 1'b0;
        a_req1 = 1'b0;
        a_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
